am_lock_ctrl: RTL and testbench

//  Per-lane alignment-marker lock controller for the 25G PCS RS-FEC receive path. Sits after amdetector, in the

---
 rtl/am_lock_ctrl_if.sv | 26 ++
 rtl/am_lock_ctrl.sv | 141 ++++++++++++++
 tb/tb_am_lock_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/am_lock_ctrl_if.sv
// Strobe bundle between amdetector and the per-lane AM lock controller.
// Every strobe is a single-cycle pulse; there is no ready, so the receiver must act in the cycle it sees it.
interface am_lock_ctrl_if;
  logic       in_isam;
  logic [2:0] in_am_field;
  logic       in_corrupt_am;
  logic       in_fec_frame_start;
  logic       relock;
  logic       am_lock;
  logic [2:0] lane_id;
  logic       am_expected;
  logic       am_err;
  logic       lock_lost;
  logic       fec_frame_start_out;
  logic [1:0] state;

  modport master (
    output in_isam, in_am_field, in_corrupt_am, in_fec_frame_start, relock,
    input  am_lock, lane_id, am_expected, am_err, lock_lost, fec_frame_start_out, state
  );

  modport slave (
    input  in_isam, in_am_field, in_corrupt_am, in_fec_frame_start, relock,
    output am_lock, lane_id, am_expected, am_err, lock_lost, fec_frame_start_out, state
  );
endinterface

// File: rtl/am_lock_ctrl.sv
// Per-lane alignment-marker lock controller: SEARCH/VERIFY/LOCKED against a fixed AM spacing.
module am_lock_ctrl #(
  parameter int AM_PERIOD = 5406720,
  parameter int VALID_N   = 2,
  parameter int MISS_N    = 4
) (
  input  logic          fullclk,
  input  logic          rst_n,
  am_lock_ctrl_if.slave bus
);
  localparam int CW = $clog2(AM_PERIOD);
  localparam int GW = $clog2(VALID_N + 1);
  localparam int BW = $clog2(MISS_N + 1);
  localparam logic [CW-1:0] SLOT_V = CW'(AM_PERIOD - 1);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [2:0]    lane_q, lane_d;
  logic          lock_q, exp_q, err_q, lost_q, fec_q;
  logic          exp_d, err_d, lost_d, fec_d;
  logic          slot, good_am, lane_ok;

  assign slot    = (cnt_q == SLOT_V);
  assign good_am = bus.in_isam & ~bus.in_corrupt_am;
  assign lane_ok = (bus.in_am_field == lane_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    bad_d   = bad_q;
    lane_d  = lane_q;
    exp_d   = 1'b0;
    err_d   = 1'b0;
    lost_d  = 1'b0;
    if (bus.relock) begin
      // Forced resync wins over slot evaluation, so no am_err is raised here.
      state_d = SEARCH;
      cnt_d   = '0;
      good_d  = '0;
      bad_d   = '0;
      lost_d  = (state_q == LOCKED);
    end else begin
      case (state_q)
        VERIFY: begin
          if (slot) begin
            exp_d = 1'b1;
            cnt_d = '0;
            if (good_am && lane_ok) begin
              if (good_q + GW'(1) >= GW'(VALID_N)) begin
                state_d = LOCKED;
                good_d  = GW'(VALID_N);
                bad_d   = '0;
              end else begin
                good_d = good_q + GW'(1);
              end
            end else begin
              // The failing AM is deliberately not reused as a fresh anchor.
              err_d   = 1'b1;
              state_d = SEARCH;
              good_d  = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        LOCKED: begin
          if (slot) begin
            exp_d = 1'b1;
            cnt_d = '0;
            if (good_am && lane_ok) begin
              bad_d = '0;
            end else begin
              err_d = 1'b1;
              if (bad_q + BW'(1) >= BW'(MISS_N)) begin
                state_d = SEARCH;
                lost_d  = 1'b1;
                bad_d   = '0;
                good_d  = '0;
              end else begin
                bad_d = bad_q + BW'(1);
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          // SEARCH, and the unused encoding which is folded back into SEARCH.
          state_d = SEARCH;
          cnt_d   = '0;
          if (good_am) begin
            lane_d  = bus.in_am_field;
            good_d  = GW'(1);
            bad_d   = '0;
            state_d = (VALID_N == 1) ? LOCKED : VERIFY;
          end
        end
      endcase
    end
    fec_d = bus.in_fec_frame_start & (state_q == LOCKED) & (state_d == LOCKED);
  end

  always_ff @(posedge fullclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      lane_q  <= '0;
      lock_q  <= 1'b0;
      exp_q   <= 1'b0;
      err_q   <= 1'b0;
      lost_q  <= 1'b0;
      fec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      lane_q  <= lane_d;
      lock_q  <= (state_d == LOCKED);
      exp_q   <= exp_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
      fec_q   <= fec_d;
    end
  end

  assign bus.am_lock             = lock_q;
  assign bus.lane_id             = lane_q;
  assign bus.am_expected         = exp_q;
  assign bus.am_err              = err_q;
  assign bus.lock_lost           = lost_q;
  assign bus.fec_frame_start_out = fec_q;
  assign bus.state               = state_q;
endmodule

// File: tb/tb_am_lock_ctrl.sv
// Bench for am_lock_ctrl: directed vector table, async reset sequence, then random AM traffic vs a reference model.
module tb_am_lock_ctrl;
  localparam int P  = 64;
  localparam int VN = 2;
  localparam int MN = 4;

  logic fullclk = 1'b0;
  logic rst_n   = 1'b1;
  always #5 fullclk = ~fullclk;

  am_lock_ctrl_if bus();

  am_lock_ctrl #(.AM_PERIOD(P), .VALID_N(VN), .MISS_N(MN)) dut (
    .fullclk (fullclk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  // Reference model: mode 0/1/2, slots are whole multiples of the period after the anchor cycle.
  int         m_mode, m_good, m_bad;
  logic [2:0] m_lane;
  longint     m_cyc, m_anchor;

  typedef struct {
    int         gap;
    logic       isam;
    logic [2:0] fld;
    logic       corrupt;
    logic       fec;
    logic       rl;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[21];

  function automatic logic [9:0] ex(int st, int lk, int ln, int xp, int er, int lo, int fc);
    return {2'(st), 1'(lk), 3'(ln), 1'(xp), 1'(er), 1'(lo), 1'(fc)};
  endfunction

  function automatic vec_t mk(int gap, int isam, int fld, int corrupt, int fec, int rl, logic [9:0] e);
    vec_t v;
    v.gap = gap; v.isam = 1'(isam); v.fld = 3'(fld); v.corrupt = 1'(corrupt);
    v.fec = 1'(fec); v.rl = 1'(rl); v.exp = e;
    return v;
  endfunction

  function automatic logic [9:0] dut_out();
    return {bus.state, bus.am_lock, bus.lane_id, bus.am_expected, bus.am_err,
            bus.lock_lost, bus.fec_frame_start_out};
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_good = 0; m_bad = 0; m_lane = 3'd0; m_anchor = 0;
  endfunction

  function automatic void model_step(logic isam, logic [2:0] fld, logic corrupt, logic fec, logic rl);
    int   old     = m_mode;
    logic xp      = 1'b0;
    logic er      = 1'b0;
    logic lo      = 1'b0;
    logic good_am = isam & ~corrupt;
    logic slot    = (m_mode != 0) && (m_cyc > m_anchor) && (((m_cyc - m_anchor) % P) == 0);
    logic match   = good_am && (fld == m_lane);
    if (rl) begin
      lo = (m_mode == 2);
      m_mode = 0; m_good = 0; m_bad = 0;
    end else if (m_mode == 0) begin
      if (good_am) begin
        m_lane = fld; m_anchor = m_cyc; m_good = 1; m_bad = 0;
        m_mode = (VN == 1) ? 2 : 1;
      end
    end else if (slot) begin
      xp = 1'b1;
      if (m_mode == 1) begin
        if (match) begin
          m_good++;
          if (m_good >= VN) begin m_mode = 2; m_bad = 0; end
        end else begin
          er = 1'b1; m_mode = 0; m_good = 0;
        end
      end else begin
        if (match) m_bad = 0;
        else begin
          er = 1'b1; m_bad++;
          if (m_bad >= MN) begin m_mode = 0; lo = 1'b1; m_bad = 0; m_good = 0; end
        end
      end
    end
    exp_q.push_back({2'(m_mode), 1'(m_mode == 2), m_lane, xp, er, lo,
                     1'(fec && old == 2 && m_mode == 2)});
    m_cyc++;
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h (state,lock,lane,exp,err,lost,fec)", name, $time, got, want);
    end
  endtask

  task automatic drive(input logic isam, input logic [2:0] fld, input logic corrupt,
                       input logic fec, input logic rl);
    bus.in_isam = isam; bus.in_am_field = fld; bus.in_corrupt_am = corrupt;
    bus.in_fec_frame_start = fec; bus.relock = rl;
    model_step(isam, fld, corrupt, fec, rl);
    @(posedge fullclk);
    #1;
    check("model", dut_out(), exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int         gen_phase;
    logic [2:0] gen_lane;
    logic       isam, corrupt, fec, rl, at_slot;
    logic [2:0] fld;

    tbl[0]  = mk(0,  1, 5, 0, 0, 0, ex(1, 0, 5, 0, 0, 0, 0));
    tbl[1]  = mk(63, 1, 5, 0, 0, 0, ex(2, 1, 5, 1, 0, 0, 0));
    tbl[2]  = mk(63, 1, 5, 0, 1, 0, ex(2, 1, 5, 1, 0, 0, 1));
    tbl[3]  = mk(63, 0, 0, 0, 0, 0, ex(2, 1, 5, 1, 1, 0, 0));
    tbl[4]  = mk(63, 0, 0, 0, 0, 0, ex(2, 1, 5, 1, 1, 0, 0));
    tbl[5]  = mk(63, 0, 0, 0, 0, 0, ex(2, 1, 5, 1, 1, 0, 0));
    tbl[6]  = mk(63, 1, 5, 0, 0, 0, ex(2, 1, 5, 1, 0, 0, 0));
    tbl[7]  = mk(63, 0, 0, 0, 0, 0, ex(2, 1, 5, 1, 1, 0, 0));
    tbl[8]  = mk(63, 0, 0, 0, 0, 0, ex(2, 1, 5, 1, 1, 0, 0));
    tbl[9]  = mk(63, 0, 0, 0, 0, 0, ex(2, 1, 5, 1, 1, 0, 0));
    tbl[10] = mk(63, 0, 0, 0, 0, 0, ex(0, 0, 5, 1, 1, 1, 0));
    tbl[11] = mk(5,  1, 5, 0, 0, 0, ex(1, 0, 5, 0, 0, 0, 0));
    tbl[12] = mk(63, 1, 2, 0, 0, 0, ex(0, 0, 5, 1, 1, 0, 0));
    tbl[13] = mk(10, 1, 2, 0, 0, 0, ex(1, 0, 2, 0, 0, 0, 0));
    tbl[14] = mk(63, 1, 2, 0, 0, 0, ex(2, 1, 2, 1, 0, 0, 0));
    tbl[15] = mk(29, 1, 2, 0, 0, 0, ex(2, 1, 2, 0, 0, 0, 0));
    tbl[16] = mk(33, 1, 2, 1, 0, 0, ex(2, 1, 2, 1, 1, 0, 0));
    tbl[17] = mk(63, 1, 2, 0, 1, 1, ex(0, 0, 2, 0, 0, 1, 0));
    tbl[18] = mk(2,  0, 0, 0, 1, 0, ex(0, 0, 2, 0, 0, 0, 0));
    tbl[19] = mk(0,  1, 3, 0, 0, 0, ex(1, 0, 3, 0, 0, 0, 0));
    tbl[20] = mk(63, 1, 3, 0, 1, 0, ex(2, 1, 3, 1, 0, 0, 0));

    // Clock/reset
    bus.in_isam = 1'b0; bus.in_am_field = 3'd0; bus.in_corrupt_am = 1'b0;
    bus.in_fec_frame_start = 1'b0; bus.relock = 1'b0;
    m_cyc = 0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge fullclk);
    #1;
    check("reset", dut_out(), ex(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 21; i++) begin
      idle(tbl[i].gap);
      drive(tbl[i].isam, tbl[i].fld, tbl[i].corrupt, tbl[i].fec, tbl[i].rl);
      check($sformatf("tbl%0d", i), dut_out(), tbl[i].exp);
    end

    // Reset dropped between edges while LOCKED, then a fresh lock needs two AMs
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", dut_out(), ex(0, 0, 0, 0, 0, 0, 0));
    model_reset();
    @(posedge fullclk);
    #1;
    check("rst_hold", dut_out(), ex(0, 0, 0, 0, 0, 0, 0));
    #3 rst_n = 1'b1;
    drive(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    check("rearm1", dut_out(), ex(1, 0, 6, 0, 0, 0, 0));
    idle(P - 1);
    drive(1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
    check("rearm2", dut_out(), ex(2, 1, 6, 1, 0, 0, 0));

    // Random traffic: mostly periodic AMs with drops, corruption, wrong lanes, stray pulses, phase jumps
    gen_phase = 7;
    gen_lane  = 3'd4;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) gen_phase = $urandom_range(0, P - 1);
      if ($urandom_range(0, 1499) == 0) gen_lane = 3'($urandom_range(0, 7));
      at_slot = ((i % P) == gen_phase);
      isam    = at_slot ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 199) == 0);
      corrupt = isam && ($urandom_range(0, 11) == 0);
      fld     = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : gen_lane;
      fec     = ($urandom_range(0, 3) == 0);
      rl      = ($urandom_range(0, 999) == 0);
      drive(isam, fld, corrupt, fec, rl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
